// File: rtl/tx_sync_scheduler.sv
// TX SYNC scheduler: counts data cycles, drains the swizzler, opens a fixed-length
// SYNC window and forwards held remote block-lock updates only inside that window.
module tx_sync_scheduler #(
    parameter int LANES         = 4,
    parameter int PERIOD_W      = 16,
    parameter int SYNC_LEN      = 2,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_enable,
    input  logic [PERIOD_W-1:0] cfg_sync_period,
    input  logic [LANES-1:0]    in_blocklock_remote,
    input  logic                in_blocklock_remote_en,
    input  logic                in_swz_empty,
    input  logic                in_swz_idle,
    output logic                out_syncing_pre,
    output logic                out_data_grant,
    output logic                out_sync_valid,
    output logic [LANES-1:0]    out_blocklock_remote,
    output logic                out_blocklock_remote_en,
    output logic                out_drain_err,
    output logic [1:0]          out_state
);

    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int SYNC_W  = $clog2(SYNC_LEN + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [SYNC_W-1:0]  SYNC_LAST  = SYNC_W'(SYNC_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SYNC  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [SYNC_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic                drain_err_q, drain_err_d;
    logic                pending_vld_q;
    logic [LANES-1:0]    pending_val_q;
    logic                syncing_pre_q;
    logic                sync_valid_q;
    logic [LANES-1:0]    blocklock_q;
    logic                blocklock_en_q;
    logic [PERIOD_W-1:0] period_last;
    logic                capture;
    logic                forward;

    assign period_last = cfg_sync_period - PERIOD_W'(1);
    // An all-zero remote value would deadlock the link, so it is never captured.
    assign capture     = in_blocklock_remote_en & (|in_blocklock_remote);

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        sync_cnt_d   = sync_cnt_q;
        drain_err_d  = drain_err_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (cfg_sync_period == '0) begin
                    period_cnt_d = '0;
                end else if (period_cnt_q == period_last) begin
                    period_cnt_d = '0;
                    state_d      = ST_DRAIN;
                end else begin
                    period_cnt_d = period_cnt_q + PERIOD_W'(1);
                end
            end
            ST_DRAIN: begin
                if (in_swz_empty && in_swz_idle) begin
                    drain_cnt_d = '0;
                    state_d     = ST_SYNC;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    drain_cnt_d = '0;
                    drain_err_d = 1'b1;
                    state_d     = ST_SYNC;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            ST_SYNC: begin
                if (sync_cnt_q == SYNC_LAST) begin
                    sync_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Forward is decided on the edge entering SYNC so the strobe lands in its first cycle.
    assign forward = (state_q == ST_DRAIN) && (state_d == ST_SYNC) && pending_vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            period_cnt_q   <= '0;
            drain_cnt_q    <= '0;
            sync_cnt_q     <= '0;
            drain_err_q    <= 1'b0;
            pending_vld_q  <= 1'b0;
            pending_val_q  <= '1;
            syncing_pre_q  <= 1'b0;
            sync_valid_q   <= 1'b0;
            blocklock_q    <= '1;
            blocklock_en_q <= 1'b0;
        end else if (in_enable) begin
            state_q        <= state_d;
            period_cnt_q   <= period_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            sync_cnt_q     <= sync_cnt_d;
            drain_err_q    <= drain_err_d;
            syncing_pre_q  <= (state_d == ST_DRAIN) || (state_d == ST_SYNC);
            sync_valid_q   <= (state_d == ST_SYNC);
            blocklock_en_q <= forward;
            if (forward) begin
                blocklock_q <= pending_val_q;
            end
            // A capture on the forward edge survives for the next window.
            if (capture) begin
                pending_val_q <= in_blocklock_remote;
                pending_vld_q <= 1'b1;
            end else if (forward) begin
                pending_vld_q <= 1'b0;
            end
        end
    end

    assign out_state               = state_q;
    assign out_data_grant          = (state_q == ST_RUN) & in_swz_idle;
    assign out_syncing_pre         = syncing_pre_q;
    assign out_sync_valid          = sync_valid_q;
    assign out_blocklock_remote    = blocklock_q;
    assign out_blocklock_remote_en = blocklock_en_q;
    assign out_drain_err           = drain_err_q;

endmodule

// File: tb/tb_tx_sync_scheduler.sv
// Directed bench for tx_sync_scheduler: period/drain/sync sequencing, timeout,
// block-lock hold-and-forward, clock-enable stretch and asynchronous reset.
module tb_tx_sync_scheduler;

    localparam int LANES         = 4;
    localparam int PERIOD_W      = 16;
    localparam int SYNC_LEN      = 2;
    localparam int DRAIN_TIMEOUT = 64;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_SYNC  = 2'd3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                in_enable;
    logic [PERIOD_W-1:0] cfg_sync_period;
    logic [LANES-1:0]    in_blocklock_remote;
    logic                in_blocklock_remote_en;
    logic                in_swz_empty;
    logic                in_swz_idle;
    logic                out_syncing_pre;
    logic                out_data_grant;
    logic                out_sync_valid;
    logic [LANES-1:0]    out_blocklock_remote;
    logic                out_blocklock_remote_en;
    logic                out_drain_err;
    logic [1:0]          out_state;

    int         err_cnt = 0;
    int         chk_cnt = 0;
    int         phase;
    int         bad;
    logic [1:0] exp_state;

    tx_sync_scheduler #(
        .LANES(LANES), .PERIOD_W(PERIOD_W), .SYNC_LEN(SYNC_LEN), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_enable(in_enable),
        .cfg_sync_period(cfg_sync_period),
        .in_blocklock_remote(in_blocklock_remote),
        .in_blocklock_remote_en(in_blocklock_remote_en),
        .in_swz_empty(in_swz_empty),
        .in_swz_idle(in_swz_idle),
        .out_syncing_pre(out_syncing_pre),
        .out_data_grant(out_data_grant),
        .out_sync_valid(out_sync_valid),
        .out_blocklock_remote(out_blocklock_remote),
        .out_blocklock_remote_en(out_blocklock_remote_en),
        .out_drain_err(out_drain_err),
        .out_state(out_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        for (int i = 0; i < budget && out_state != s; i++) step();
        chk(tag, 32'(out_state), 32'(s));
    endtask

    initial begin
        reset_n                = 1'b1;
        in_enable              = 1'b0;
        cfg_sync_period        = 16'd8;
        in_blocklock_remote    = '0;
        in_blocklock_remote_en = 1'b0;
        in_swz_empty           = 1'b1;
        in_swz_idle            = 1'b1;
        #2 reset_n = 1'b0;
        step();
        step();

        // reset values
        chk("rst_state", 32'(out_state), 32'(S_IDLE));
        chk("rst_pre", 32'(out_syncing_pre), 0);
        chk("rst_grant", 32'(out_data_grant), 0);
        chk("rst_valid", 32'(out_sync_valid), 0);
        chk("rst_bl", 32'(out_blocklock_remote), 32'hF);
        chk("rst_bl_en", 32'(out_blocklock_remote_en), 0);
        chk("rst_err", 32'(out_drain_err), 0);
        in_enable = 1'b1;
        step();
        chk("rst_hold_state", 32'(out_state), 32'(S_IDLE));
        reset_n = 1'b1;
        step();

        // test 1: RUN x8, DRAIN x1, SYNC x2 repeating
        for (int c = 0; c < 22; c++) begin
            phase     = c % 11;
            exp_state = (phase < 8) ? S_RUN : ((phase == 8) ? S_DRAIN : S_SYNC);
            chk("t1_state", 32'(out_state), 32'(exp_state));
            chk("t1_grant", 32'(out_data_grant), 32'(exp_state == S_RUN));
            chk("t1_valid", 32'(out_sync_valid), 32'(exp_state == S_SYNC));
            chk("t1_pre", 32'(out_syncing_pre), 32'(exp_state == S_DRAIN || exp_state == S_SYNC));
            chk("t1_bl_en", 32'(out_blocklock_remote_en), 0);
            step();
        end

        // test 4: capture 1011, drop 0000, forward at first SYNC cycle
        chk("t4_start", 32'(out_state), 32'(S_RUN));
        in_blocklock_remote    = 4'b1011;
        in_blocklock_remote_en = 1'b1;
        step();
        in_blocklock_remote    = 4'b0000;
        step();
        in_blocklock_remote_en = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t4_drain_state", 32'(out_state), 32'(S_DRAIN));
        chk("t4_drain_bl_en", 32'(out_blocklock_remote_en), 0);
        step();
        chk("t4_sync_state", 32'(out_state), 32'(S_SYNC));
        chk("t4_fwd_en", 32'(out_blocklock_remote_en), 1);
        chk("t4_fwd_val", 32'(out_blocklock_remote), 32'hB);
        step();
        chk("t4_one_shot", 32'(out_blocklock_remote_en), 0);
        chk("t4_val_hold", 32'(out_blocklock_remote), 32'hB);

        // test 5: new capture on the forward edge waits for the next window
        step();
        for (int i = 0; i < 3; i++) step();
        in_blocklock_remote    = 4'b1011;
        in_blocklock_remote_en = 1'b1;
        step();
        in_blocklock_remote_en = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_drain", 32'(out_state), 32'(S_DRAIN));
        in_blocklock_remote    = 4'b0111;
        in_blocklock_remote_en = 1'b1;
        step();
        in_blocklock_remote_en = 1'b0;
        chk("t5_fwd1_en", 32'(out_blocklock_remote_en), 1);
        chk("t5_fwd1_val", 32'(out_blocklock_remote), 32'hB);
        step();
        chk("t5_fwd1_off", 32'(out_blocklock_remote_en), 0);
        for (int i = 0; i < 10; i++) step();
        chk("t5_win2_state", 32'(out_state), 32'(S_SYNC));
        chk("t5_fwd2_en", 32'(out_blocklock_remote_en), 1);
        chk("t5_fwd2_val", 32'(out_blocklock_remote), 32'h7);

        // test 2: swizzler not empty for 10 DRAIN cycles -> DRAIN lasts 11
        wait_state(S_RUN, 20, "t2_run");
        in_swz_empty = 1'b0;
        wait_state(S_DRAIN, 20, "t2_drain");
        for (int k = 0; k < 10; k++) begin
            chk("t2_hold", 32'(out_state), 32'(S_DRAIN));
            step();
        end
        chk("t2_last", 32'(out_state), 32'(S_DRAIN));
        chk("t2_pre", 32'(out_syncing_pre), 1);
        chk("t2_grant", 32'(out_data_grant), 0);
        in_swz_empty = 1'b1;
        step();
        chk("t2_sync", 32'(out_state), 32'(S_SYNC));
        chk("t2_err", 32'(out_drain_err), 0);
        chk("t2_no_fwd", 32'(out_blocklock_remote_en), 0);

        // test 3: DRAIN timeout after 64 cycles sets sticky error
        wait_state(S_RUN, 20, "t3_run");
        in_swz_empty = 1'b0;
        wait_state(S_DRAIN, 20, "t3_drain");
        for (int k = 0; k < 63; k++) step();
        chk("t3_last", 32'(out_state), 32'(S_DRAIN));
        chk("t3_err_before", 32'(out_drain_err), 0);
        step();
        chk("t3_sync", 32'(out_state), 32'(S_SYNC));
        chk("t3_err_set", 32'(out_drain_err), 1);
        in_swz_empty = 1'b1;

        // test 6a: enable low 5 cycles in SYNC stretches the window to 7 cycles
        wait_state(S_RUN, 20, "t6a_run");
        wait_state(S_SYNC, 30, "t6a_sync");
        chk("t6a_valid0", 32'(out_sync_valid), 1);
        in_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6a_frozen_valid", 32'(out_sync_valid), 1);
            chk("t6a_frozen_pre", 32'(out_syncing_pre), 1);
        end
        in_enable = 1'b1;
        step();
        chk("t6a_valid_last", 32'(out_sync_valid), 1);
        step();
        chk("t6a_valid_off", 32'(out_sync_valid), 0);
        chk("t6a_pre_off", 32'(out_syncing_pre), 0);
        chk("t6a_run", 32'(out_state), 32'(S_RUN));
        chk("t6a_err_sticky", 32'(out_drain_err), 1);

        // test 6b: period 0 disables SYNC insertion
        cfg_sync_period = 16'd0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_state != S_RUN || out_sync_valid) bad++;
        end
        chk("t6b_no_sync", 32'(bad), 0);

        // test 6c: reset mid-DRAIN returns to reset values immediately
        cfg_sync_period = 16'd8;
        in_swz_empty    = 1'b0;
        wait_state(S_DRAIN, 20, "t6c_drain");
        step();
        step();
        chk("t6c_in_drain", 32'(out_state), 32'(S_DRAIN));
        reset_n = 1'b0;
        #1;
        chk("t6c_state", 32'(out_state), 32'(S_IDLE));
        chk("t6c_pre", 32'(out_syncing_pre), 0);
        chk("t6c_valid", 32'(out_sync_valid), 0);
        chk("t6c_grant", 32'(out_data_grant), 0);
        chk("t6c_err", 32'(out_drain_err), 0);
        chk("t6c_bl", 32'(out_blocklock_remote), 32'hF);
        chk("t6c_bl_en", 32'(out_blocklock_remote_en), 0);
        #2 reset_n = 1'b1;
        in_swz_empty = 1'b1;
        step();
        chk("t6c_restart", 32'(out_state), 32'(S_RUN));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/tx_sync_scheduler.md
Name: tx_sync_scheduler

Overview:
- Sequences the TX swizzler around periodic SYNC insertion.
- Counts data cycles and raises the pre-sync indication so the swizzler flushes. It then waits for the swizzler to report empty and idle, and opens a SYNC window of fixed length.
- Remote block-lock updates from the RX side are held and forwarded to the swizzler only inside the SYNC window. This way a block-lock change never flushes buffered payload.
- Sits between the TX distributor/lane logic and tx_swizzler.

Parameters:
- LANES, 4, lane count; width of the block-lock vectors.
- PERIOD_W, 16, width of the sync-period counter and of cfg_sync_period.
- SYNC_LEN, 2, cycles (enabled) that out_sync_valid is held per SYNC window; minimum 1.
- DRAIN_TIMEOUT, 64, maximum enabled cycles spent in DRAIN before a forced SYNC.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_enable  in  1  clock enable; all state and counters freeze while low.
- cfg_sync_period  in  PERIOD_W  data cycles between SYNC windows; 0 disables SYNC insertion.
- in_blocklock_remote  in  LANES  remote block-lock vector from RX.
- in_blocklock_remote_en  in  1  qualifies in_blocklock_remote.
- in_swz_empty  in  1  swizzler buffer empty.
- in_swz_idle  in  1  swizzler ready for new data.
- out_syncing_pre  out  1  to swizzler: flush and stop accepting data.
- out_data_grant  out  1  upstream may present data this cycle.
- out_sync_valid  out  1  lane logic must emit SYNC blocks this cycle.
- out_blocklock_remote  out  LANES  block-lock value forwarded to the swizzler.
- out_blocklock_remote_en  out  1  one-cycle strobe qualifying out_blocklock_remote.
- out_drain_err  out  1  sticky flag: a DRAIN timed out.
- out_state  out  2  encoding: 0 IDLE, 1 RUN, 2 DRAIN, 3 SYNC.

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - Period, drain and sync counters = 0.
  - pending_vld = 0, pending_val = all 1s.
  - out_blocklock_remote = all 1s.
  - All other outputs = 0.
- Registers update only on clk edges with in_enable = 1. Outputs are registered unless stated.
- IDLE:
  - Next enabled cycle goes to RUN.
  - Outputs all deasserted.
- RUN:
  - out_data_grant = in_swz_idle (combinational AND with state).
  - Period counter increments each enabled cycle.
  - When the counter equals cfg_sync_period−1 and cfg_sync_period ≠ 0: counter ← 0, go to DRAIN.
  - cfg_sync_period = 0: counter held at 0, stays in RUN.
  - If cfg_sync_period changes below the current count, the counter wraps naturally at 2^PERIOD_W; no special handling.
- DRAIN:
  - out_syncing_pre = 1, out_data_grant = 0.
  - Drain counter increments each enabled cycle.
  - in_swz_empty & in_swz_idle sampled high → SYNC; drain counter ← 0.
  - Drain counter reaches DRAIN_TIMEOUT−1 → out_drain_err ← 1 (sticky until reset), go to SYNC anyway.
- SYNC:
  - out_syncing_pre = 1 and out_sync_valid = 1 for exactly SYNC_LEN enabled cycles, then RUN.
  - On the RUN transition, out_syncing_pre, out_sync_valid and the sync counter all clear.
- Block-lock capture:
  - In any state, in_blocklock_remote_en & (in_blocklock_remote ≠ 0) → pending_val ← input, pending_vld ← 1.
  - An all-zero value is dropped; this is the deadlock rule.
  - A later capture overwrites an earlier unforwarded one.
- Block-lock forward:
  - Happens in the first SYNC cycle only, if pending_vld = 1.
  - out_blocklock_remote ← pending_val, out_blocklock_remote_en = 1 for exactly one cycle, pending_vld ← 0.
  - If a capture coincides with the forward cycle: the old pending_val is forwarded, and the new value is retained with pending_vld = 1 for the next window.
- out_blocklock_remote_en is never asserted outside SYNC.
- in_enable low mid-window: the window stretches; counts are in enabled cycles only. out_sync_valid and out_syncing_pre hold their value.
- Reset asserted mid-window: immediate return to the reset values. No partial SYNC is completed.

Test Plan:
1. cfg_sync_period=8, SYNC_LEN=2, swizzler empty and idle always → states RUN×8, DRAIN×1, SYNC×2, repeating; out_data_grant high only in RUN; out_sync_valid high 2 cycles per 11.
2. in_swz_empty held low 10 cycles into DRAIN → DRAIN lasts 11 cycles, then SYNC; out_drain_err stays 0.
3. in_swz_empty held low permanently, DRAIN_TIMEOUT=64 → SYNC entered after 64 DRAIN cycles; out_drain_err=1 until reset.
4. Inject blocklock 4'b1011 during RUN, then 4'b0000 → at the first SYNC cycle out_blocklock_remote_en pulses once with out_blocklock_remote=4'b1011; the zero value is ignored.
5. Inject 4'b0111 while 4'b1011 is being forwarded → 4'b1011 forwarded this window, 4'b0111 forwarded next window.
6. cfg_sync_period=0 → permanent RUN with no SYNC windows. in_enable low for 5 cycles inside SYNC → out_sync_valid held for 5+SYNC_LEN cycles. reset_n pulsed mid-DRAIN → IDLE with all outputs at reset values.
